// File: rtl/plab4_net_mux_arb_pkg.sv
// rtl/plab4_net_mux_arb_pkg.sv - shared encodings and default widths for the domain merge stage
package plab4_net_mux_arb_pkg;

    typedef enum logic {
        DOMAIN_D1 = 1'b0,
        DOMAIN_D2 = 1'b1
    } domain_e;

    typedef enum logic {
        STATE_EMPTY = 1'b0,
        STATE_FULL  = 1'b1
    } state_e;

    localparam int DEF_CNBITS = 32;
    localparam int DEF_DNBITS = 32;

    // One-hot grant to the domain it selects; an empty grant maps to d1.
    function automatic domain_e domain_of(input logic [1:0] grant);
        return grant[1] ? DOMAIN_D2 : DOMAIN_D1;
    endfunction

endpackage

// File: rtl/plab4_net_rr_arb2.sv
// rtl/plab4_net_rr_arb2.sv - two-input round-robin arbiter owning the priority pointer
module plab4_net_rr_arb2
    import plab4_net_mux_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    domain_e ptr_q;
    domain_e ptr_d;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (ptr_q == DOMAIN_D2) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && (grant != 2'b00)) begin
            ptr_d = (domain_of(grant) == DOMAIN_D2) ? DOMAIN_D1 : DOMAIN_D2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= DOMAIN_D1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/plab4_net_mux_arb.sv
// rtl/plab4_net_mux_arb.sv - merges two domain streams into one tagged stream via a one-entry buffer
module plab4_net_mux_arb
    import plab4_net_mux_arb_pkg::*;
#(
    parameter int p_msg_cnbits = DEF_CNBITS,
    parameter int p_msg_dnbits = DEF_DNBITS
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    in_val_d1,
    output logic                    in_rdy_d1,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d1,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d1,

    input  logic                    in_val_d2,
    output logic                    in_rdy_d2,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d2,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d2,

    output logic                    out_val,
    input  logic                    out_rdy,
    output logic                    out_domain,
    output logic [p_msg_cnbits-1:0] out_msg_control,
    output logic [p_msg_dnbits-1:0] out_msg_data
);

    state_e                  state_q;
    state_e                  state_d;
    domain_e                 dom_q;
    domain_e                 dom_d;
    logic [p_msg_cnbits-1:0] ctrl_q;
    logic [p_msg_cnbits-1:0] ctrl_d;
    logic [p_msg_dnbits-1:0] data_q;
    logic [p_msg_dnbits-1:0] data_d;

    logic [1:0] req;
    logic [1:0] grant;
    logic       can_fill;
    logic       drain;
    logic       accept;

    assign req      = {in_val_d2, in_val_d1};
    assign out_val  = (state_q == STATE_FULL);
    assign drain    = out_val & out_rdy;
    assign can_fill = (state_q == STATE_EMPTY) | drain;
    assign accept   = can_fill & (req != 2'b00);

    assign in_rdy_d1 = can_fill & grant[0];
    assign in_rdy_d2 = can_fill & grant[1];

    plab4_net_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .en    (accept),
        .grant (grant)
    );

    // Drain without refill scrubs the payload so an idle channel carries nothing stale;
    // the domain tag is left as it was.
    always_comb begin
        state_d = state_q;
        dom_d   = dom_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (accept) begin
            state_d = STATE_FULL;
            dom_d   = domain_of(grant);
            if (domain_of(grant) == DOMAIN_D2) begin
                ctrl_d = in_msg_control_d2;
                data_d = in_msg_data_d2;
            end else begin
                ctrl_d = in_msg_control_d1;
                data_d = in_msg_data_d1;
            end
        end else if (drain) begin
            state_d = STATE_EMPTY;
            ctrl_d  = '0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STATE_EMPTY;
            dom_q   <= DOMAIN_D1;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            dom_q   <= dom_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign out_domain      = dom_q;
    assign out_msg_control = ctrl_q;
    assign out_msg_data    = data_q;

endmodule

// File: tb/tb_plab4_net_mux_arb.sv
// tb/tb_plab4_net_mux_arb.sv - self-checking bench for the domain merge stage
module tb_plab4_net_mux_arb;

    logic        clk;
    logic        reset;
    logic        in_val_d1;
    logic        in_rdy_d1;
    logic [31:0] in_msg_control_d1;
    logic [31:0] in_msg_data_d1;
    logic        in_val_d2;
    logic        in_rdy_d2;
    logic [31:0] in_msg_control_d2;
    logic [31:0] in_msg_data_d2;
    logic        out_val;
    logic        out_rdy;
    logic        out_domain;
    logic [31:0] out_msg_control;
    logic [31:0] out_msg_data;

    int n_checks = 0;
    int n_fail   = 0;

    plab4_net_mux_arb #(.p_msg_cnbits(32), .p_msg_dnbits(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_val_d1         (in_val_d1),
        .in_rdy_d1         (in_rdy_d1),
        .in_msg_control_d1 (in_msg_control_d1),
        .in_msg_data_d1    (in_msg_data_d1),
        .in_val_d2         (in_val_d2),
        .in_rdy_d2         (in_rdy_d2),
        .in_msg_control_d2 (in_msg_control_d2),
        .in_msg_data_d2    (in_msg_data_d2),
        .out_val           (out_val),
        .out_rdy           (out_rdy),
        .out_domain        (out_domain),
        .out_msg_control   (out_msg_control),
        .out_msg_data      (out_msg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the channel is "what the last event left there": a message after an accept,
    // zero payload after a drain, everything zero after reset.
    bit          m_full, m_dom, m_ptr;
    logic [31:0] m_ctrl, m_data;
    bit          n_full, n_dom, n_ptr;
    logic [31:0] n_ctrl, n_data;
    logic [32:0] drained[$];

    function automatic int winner(input bit v1, input bit v2, input bit ptr);
        if (v1 && v2) return ptr ? 1 : 0;
        if (v1) return 0;
        if (v2) return 1;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_full = 0; m_dom = 0; m_ptr = 0; m_ctrl = '0; m_data = '0;
            n_full = 0; n_dom = 0; n_ptr = 0; n_ctrl = '0; n_data = '0;
        end else begin
            bit free_slot;
            int w;
            free_slot = !m_full || out_rdy;
            w = free_slot ? winner(in_val_d1, in_val_d2, m_ptr) : -1;
            chk("model_out_val", 64'(out_val), 64'(m_full));
            chk("model_out_domain", 64'(out_domain), 64'(m_dom));
            chk("model_out_ctrl", 64'(out_msg_control), 64'(m_ctrl));
            chk("model_out_data", 64'(out_msg_data), 64'(m_data));
            chk("model_rdy_d1", 64'(in_rdy_d1), 64'(w == 0));
            chk("model_rdy_d2", 64'(in_rdy_d2), 64'(w == 1));
            if (m_full && out_rdy) drained.push_back({m_dom, m_data});
            n_full = m_full; n_dom = m_dom; n_ptr = m_ptr; n_ctrl = m_ctrl; n_data = m_data;
            if (w >= 0) begin
                n_full = 1;
                n_dom  = (w == 1);
                n_ptr  = (w == 0);
                n_ctrl = (w == 1) ? in_msg_control_d2 : in_msg_control_d1;
                n_data = (w == 1) ? in_msg_data_d2 : in_msg_data_d1;
            end else if (m_full && out_rdy) begin
                n_full = 0; n_ctrl = '0; n_data = '0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_full = 0; m_dom = 0; m_ptr = 0; m_ctrl = '0; m_data = '0;
        end else begin
            m_full = n_full; m_dom = n_dom; m_ptr = n_ptr; m_ctrl = n_ctrl; m_data = n_data;
        end
    end

    task automatic drive(input bit v1, input logic [31:0] d1, input bit v2,
                         input logic [31:0] d2, input bit ordy);
        in_val_d1 = v1; in_msg_data_d1 = d1; in_msg_control_d1 = ~d1;
        in_val_d2 = v2; in_msg_data_d2 = d2; in_msg_control_d2 = {d2[15:0], d2[31:16]};
        out_rdy = ordy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n1, n2;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        #2;
        chk("rst_out_val", 64'(out_val), 64'd0);
        chk("rst_out_data", 64'(out_msg_data), 64'd0);
        chk("rst_out_domain", 64'(out_domain), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Asynchronous reset with a full buffer; pointer was moved to d2 by the accept.
        drive(1, 32'hDEADBEEF, 0, 0, 0);
        cyc();
        chk("pre_rst_data", 64'(out_msg_data), 64'hDEADBEEF);
        drive(0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_val", 64'(out_val), 64'd0);
        chk("async_rst_data", 64'(out_msg_data), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Contention straight after reset: d1 first, then alternate.
        drained.delete();
        n1 = 0; n2 = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'hA0 + n1, 1, 32'hB0 + n2, 1);
            #1;
            if (in_rdy_d1) n1++;
            if (in_rdy_d2) n2++;
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 1);
        cyc(); cyc();
        chk("cont_count", 64'(drained.size()), 64'd5);
        if (drained.size() >= 4) begin
            chk("cont_0", 64'(drained[0]), {31'd0, 1'b0, 32'hA0});
            chk("cont_1", 64'(drained[1]), {31'd0, 1'b1, 32'hB0});
            chk("cont_2", 64'(drained[2]), {31'd0, 1'b0, 32'hA1});
            chk("cont_3", 64'(drained[3]), {31'd0, 1'b1, 32'hB1});
        end

        // Single-domain streaming, one message per cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h11 + i, 0, 0, 1);
            #1;
            chk("stream_rdy_d2", 64'(in_rdy_d2), 64'd0);
            @(posedge clk); #1;
            chk("stream_val", 64'(out_val), 64'd1);
            chk("stream_data", 64'(out_msg_data), 64'h11 + i);
            chk("stream_dom", 64'(out_domain), 64'd0);
        end
        drive(0, 0, 0, 0, 1);
        cyc(); cyc();

        // Backpressure holding a d2 message while d1 waits.
        drive(0, 0, 1, 32'h55, 1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h77, 0, 0, 0);
            #1;
            chk("bp_rdy_d1", 64'(in_rdy_d1), 64'd0);
            chk("bp_rdy_d2", 64'(in_rdy_d2), 64'd0);
            @(posedge clk); #1;
            chk("bp_data", 64'(out_msg_data), 64'h55);
            chk("bp_dom", 64'(out_domain), 64'd1);
        end
        out_rdy = 1'b1;
        #1;
        chk("bp_release_rdy_d1", 64'(in_rdy_d1), 64'd1);
        cyc();
        chk("bp_release_data", 64'(out_msg_data), 64'h77);
        chk("bp_release_dom", 64'(out_domain), 64'd0);
        drive(0, 0, 0, 0, 1);
        cyc(); cyc();

        // Drain scrub after a lone d2 message.
        drive(0, 0, 1, 32'hCAFE, 1);
        cyc();
        chk("scrub_loaded_ctrl", 64'(out_msg_control), 64'hCAFE_0000);
        drive(0, 0, 0, 0, 1);
        cyc();
        chk("scrub_val", 64'(out_val), 64'd0);
        chk("scrub_data", 64'(out_msg_data), 64'd0);
        chk("scrub_ctrl", 64'(out_msg_control), 64'd0);
        chk("scrub_dom", 64'(out_domain), 64'd1);

        // Pointer holds across idle cycles: d1 still preferred after the d2 accept.
        for (int i = 0; i < 4; i++) cyc();
        drive(1, 32'h1D1, 1, 32'h2D2, 1);
        #1;
        chk("idle_rdy_d1", 64'(in_rdy_d1), 64'd1);
        chk("idle_rdy_d2", 64'(in_rdy_d2), 64'd0);
        cyc();
        chk("idle_win_dom", 64'(out_domain), 64'd0);
        chk("idle_win_data", 64'(out_msg_data), 64'h1D1);
        drive(0, 0, 0, 0, 1);
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plab4_net_mux_arb.md
Name: plab4_net_mux_arb

Overview:
- Merge stage, the inverse of the network's domain demux. Two domain-private input streams (domain 0 "d1", domain 1 "d2") are combined into one shared output stream tagged with a domain bit.
- A two-way round-robin arbiter picks the next source. A one-entry registered output buffer holds the winning message.
- Sits at a router/terminal injection point, ahead of the shared channel whose far end is the demux.

Parameters:
- p_msg_cnbits, 32, width of the control (header) field.
- p_msg_dnbits, 32, width of the data (payload) field.

Ports:
- clk  input  1  clock.
- reset  input  1  reset; asynchronous, active-high.
- in_val_d1  input  1  domain-0 message valid.
- in_rdy_d1  output  1  domain-0 message accepted when high together with in_val_d1.
- in_msg_control_d1  input  p_msg_cnbits  domain-0 control.
- in_msg_data_d1  input  p_msg_dnbits  domain-0 data.
- in_val_d2  input  1  domain-1 message valid.
- in_rdy_d2  output  1  domain-1 ready.
- in_msg_control_d2  input  p_msg_cnbits  domain-1 control.
- in_msg_data_d2  input  p_msg_dnbits  domain-1 data.
- out_val  output  1  buffered message valid.
- out_rdy  input  1  downstream ready.
- out_domain  output  1  domain tag of the buffered message (0=d1, 1=d2).
- out_msg_control  output  p_msg_cnbits  buffered control.
- out_msg_data  output  p_msg_dnbits  buffered data.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-high. All state is cleared immediately on reset assertion, independent of clk.
  - Reset values: out_val=0, out_domain=0, out_msg_control=0, out_msg_data=0, rr priority pointer=0 (d1 preferred).
  - Reset asserted mid-transfer drops the buffered message; there is no replay.
- Buffer state machine (2 states):
  - EMPTY: out_val=0.
  - FULL: out_val=1; out_domain, out_msg_control and out_msg_data are stable until the entry drains.
  - can_fill = (state==EMPTY) | (out_val & out_rdy). Fill and drain in the same cycle are allowed, giving full throughput: one message per cycle.
- Arbitration (combinational each cycle):
  - req = {in_val_d2, in_val_d1}.
  - With a single requester, that requester wins.
  - With both requesting, the domain selected by the pointer wins.
  - in_rdy_dX = can_fill & grant_X. At most one in_rdy is high in any cycle. in_rdy_dX is never asserted for a domain that is not granted.
  - in_rdy may depend combinationally on out_rdy. No input depends combinationally on in_rdy.
- Accept (in_val_dX & in_rdy_dX at the clock edge):
  - Buffer loads the winner's control and data; out_domain is set to X; state becomes FULL; latency is 1 cycle to out_val.
  - Pointer moves to the other domain (pointer = ~X).
  - The pointer changes only on accept, never on idle cycles.
- Drain without fill (out_val & out_rdy, no accept):
  - State becomes EMPTY.
  - out_msg_data and out_msg_control are scrubbed to 0, so an idle channel carries no stale payload.
  - out_domain holds its last value.
- Backpressure (out_val & ~out_rdy):
  - Buffer holds; both in_rdy are 0; the pointer is frozen.
  - Inputs that change while not accepted are ignored.
- Fairness:
  - With both domains continuously valid and out_rdy=1, grants alternate d1,d2,d1,... starting from the pointer value.
  - Neither domain waits more than one accepted message while the other is served.
- Width rules: no arithmetic is performed. Fields pass through bit-exact, with no truncation or extension.

Decomposition:
- Shared net package/header:
  - Domain encodings: DOMAIN_D1=1'b0, DOMAIN_D2=1'b1.
  - Buffer state encodings: STATE_EMPTY, STATE_FULL.
  - Default field widths.
- Sub-module plab4_net_rr_arb2:
  - Two-input round-robin arbiter: req[1:0], an enable that advances the pointer, grant[1:0].
  - Owns the pointer flop with asynchronous active-high reset.
  - plab4_net_mux_arb instantiates it once and holds the buffer and scrub logic.

Test Plan:
- Reset: assert reset mid-cycle with the buffer FULL (data 0xDEADBEEF). Required: out_val falls to 0 and out_msg_data reads 0 before the next clk edge; pointer=0 after release.
- Single domain, streaming: in_val_d1=1 for 4 cycles with data 0x11..0x14, out_rdy=1. Required: out_val from cycle 1, data 0x11,0x12,0x13,0x14 on consecutive cycles, out_domain=0, in_rdy_d2=0 throughout.
- Contention: both valid every cycle (d1 data 0xA0+n, d2 data 0xB0+n), out_rdy=1 after reset. Required: output 0xA0,0xB0,0xA1,0xB1 with out_domain 0,1,0,1.
- Backpressure: buffer FULL with d2 message 0x55, out_rdy=0 for 3 cycles, d1 valid. Required: out_msg_data stays 0x55 with out_domain=1, and in_rdy_d1=in_rdy_d2=0. When out_rdy rises, the d1 message loads on the next edge.
- Drain-scrub: single d2 message 0xCAFE accepted, then no inputs valid, out_rdy=1. Required: the cycle after drain has out_val=0, out_msg_data=0, out_msg_control=0, out_domain=1.
- Pointer idle-hold: d2 accepted, then 5 idle cycles, then both valid. Required: d1 wins first.
